// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe board datapath.
package ttt_pkg;

  typedef enum logic [1:0] {READY, COMMIT, HOLD} mc_state_t;

  localparam logic PLAYER_X = 1'b0;
  localparam logic PLAYER_O = 1'b1;

  localparam int unsigned BOARD_N_DEF = 3;

endpackage

// File: rtl/move_controller_if.sv
// Key inputs, board status and cell-select outputs of the move controller.
interface move_controller_if
  import ttt_pkg::*;
#(
  parameter int unsigned BOARD_N = BOARD_N_DEF
);
  localparam int unsigned NUM_CELLS = BOARD_N * BOARD_N;
  localparam int unsigned IW        = (BOARD_N > 1) ? $clog2(BOARD_N) : 1;

  logic                 key_up;
  logic                 key_down;
  logic                 key_left;
  logic                 key_right;
  logic                 key_place;
  logic [NUM_CELLS-1:0] occupied;
  logic                 game_over;
  logic [IW-1:0]        row;
  logic [IW-1:0]        col;
  logic [NUM_CELLS-1:0] select;
  logic                 player;
  logic [3:0]           move_count;

  // Keypad/board side.
  modport master (
    output key_up, key_down, key_left, key_right, key_place, occupied, game_over,
    input  row, col, select, player, move_count
  );

  // Controller side.
  modport slave (
    input  key_up, key_down, key_left, key_right, key_place, occupied, game_over,
    output row, col, select, player, move_count
  );

endinterface

// File: rtl/rise_edge.sv
// One-bit rising-edge detector: pulse is high while d is 1 and was 0 last cycle.
module rise_edge (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= d;
    end
  end

  assign pulse = d & ~prev_q;

endmodule

// File: rtl/move_controller.sv
// Cursor, placement FSM and current-player bit feeding the board cells.
module move_controller
  import ttt_pkg::*;
#(
  parameter int unsigned BOARD_N      = BOARD_N_DEF,
  parameter logic        FIRST_PLAYER = PLAYER_X
) (
  input logic              clock,
  input logic              reset,
  move_controller_if.slave bus
);

  localparam int unsigned NumCells = BOARD_N * BOARD_N;
  localparam int unsigned Iw       = (BOARD_N > 1) ? $clog2(BOARD_N) : 1;
  localparam int unsigned IdxW     = (NumCells > 1) ? $clog2(NumCells) : 1;
  localparam logic [Iw-1:0] PosMax   = Iw'(BOARD_N - 1);
  localparam logic [3:0]    CountMax = 4'(NumCells);

  mc_state_t            state_q, state_d;
  logic [Iw-1:0]        row_q, row_d, col_q, col_d;
  logic [NumCells-1:0]  select_q, select_d;
  logic                 player_q, player_d;
  logic [3:0]           count_q, count_d;
  logic                 up_e, down_e, left_e, right_e, place_e;
  logic [IdxW-1:0]      idx;
  logic                 accept;

  rise_edge u_edge_up    (.clock(clock), .reset(reset), .d(bus.key_up),    .pulse(up_e));
  rise_edge u_edge_down  (.clock(clock), .reset(reset), .d(bus.key_down),  .pulse(down_e));
  rise_edge u_edge_left  (.clock(clock), .reset(reset), .d(bus.key_left),  .pulse(left_e));
  rise_edge u_edge_right (.clock(clock), .reset(reset), .d(bus.key_right), .pulse(right_e));
  rise_edge u_edge_place (.clock(clock), .reset(reset), .d(bus.key_place), .pulse(place_e));

  // Opposite edges in the same cycle cancel; otherwise step with wrap-around.
  function automatic logic [Iw-1:0] step(input logic [Iw-1:0] v, input logic dec,
                                         input logic inc);
    if (dec && !inc) return (v == '0) ? PosMax : v - 1'b1;
    if (inc && !dec) return (v == PosMax) ? '0 : v + 1'b1;
    return v;
  endfunction

  assign idx    = IdxW'(row_q) * IdxW'(BOARD_N) + IdxW'(col_q);
  assign accept = place_e && !bus.occupied[idx] && !bus.game_over && (count_q < CountMax);

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    select_d = '0;
    player_d = player_q;
    count_d  = count_q;
    unique case (state_q)
      READY: begin
        if (place_e) begin
          // Any place edge freezes the cursor this cycle, accepted or not.
          if (accept) begin
            state_d  = COMMIT;
            select_d = NumCells'(1) << idx;
          end
        end else begin
          row_d = step(row_q, up_e, down_e);
          col_d = step(col_q, left_e, right_e);
        end
      end
      COMMIT: begin
        state_d  = HOLD;
        player_d = ~player_q;
        if (count_q < CountMax) count_d = count_q + 4'd1;
      end
      HOLD: begin
        if (!bus.key_place) state_d = READY;
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= READY;
      row_q    <= '0;
      col_q    <= '0;
      select_q <= '0;
      player_q <= FIRST_PLAYER;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      select_q <= select_d;
      player_q <= player_d;
      count_q  <= count_d;
    end
  end

  assign bus.row        = row_q;
  assign bus.col        = col_q;
  assign bus.select     = select_q;
  assign bus.player     = player_q;
  assign bus.move_count = count_q;

endmodule

// File: tb/tb_move_controller.sv
// Directed self-checking bench for move_controller on a 3x3 board.
module tb_move_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pulses;

  move_controller_if #(.BOARD_N(3)) bus ();

  move_controller #(.BOARD_N(3), .FIRST_PLAYER(1'b0)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.key_up = 0; bus.key_down = 0; bus.key_left = 0; bus.key_right = 0;
    bus.key_place = 0; bus.occupied = '0; bus.game_over = 0;

    // 1. reset state
    tick(); tick();
    rst = 0;
    tick(); tick(); tick();
    chk("rst_row", 32'(bus.row), 0);
    chk("rst_col", 32'(bus.col), 0);
    chk("rst_select", 32'(bus.select), 0);
    chk("rst_player", 32'(bus.player), 0);
    chk("rst_count", 32'(bus.move_count), 0);

    // 2. cursor movement with wrap and held key
    bus.key_up = 1; tick(); bus.key_up = 0; tick();
    chk("up_wrap_row", 32'(bus.row), 2);
    bus.key_right = 1;
    for (int i = 0; i < 5; i++) tick();
    bus.key_right = 0; tick();
    chk("right_held_col", 32'(bus.col), 1);
    bus.key_down = 1; tick(); bus.key_down = 0; tick();
    chk("down_wrap_row", 32'(bus.row), 0);
    bus.key_down = 1; tick(); bus.key_down = 0; tick();
    chk("at_11_row", 32'(bus.row), 1);
    chk("at_11_col", 32'(bus.col), 1);

    // 3. first placement at (1,1)
    bus.key_place = 1; tick();
    chk("p1_select", 32'(bus.select), 32'h010);
    chk("p1_player_pre", 32'(bus.player), 0);
    tick();
    chk("p1_select_clear", 32'(bus.select), 0);
    chk("p1_player_post", 32'(bus.player), 1);
    chk("p1_count", 32'(bus.move_count), 1);
    bus.key_place = 0; tick();

    // 4. occupied cell rejected
    bus.occupied = 9'h010;
    bus.key_place = 1; tick();
    chk("occ_select", 32'(bus.select), 0);
    tick();
    chk("occ_select2", 32'(bus.select), 0);
    bus.key_place = 0; tick();
    chk("occ_player", 32'(bus.player), 1);
    chk("occ_count", 32'(bus.move_count), 1);

    // game over: cursor moves, empty cell (1,2) still rejected
    bus.game_over = 1;
    bus.key_right = 1; tick(); bus.key_right = 0; tick();
    chk("go_col", 32'(bus.col), 2);
    bus.key_place = 1; tick();
    chk("go_select", 32'(bus.select), 0);
    bus.key_place = 0; tick();
    chk("go_player", 32'(bus.player), 1);
    chk("go_count", 32'(bus.move_count), 1);
    bus.game_over = 0;

    // 5. second placement at (1,2), held place key, up during HOLD
    bus.key_place = 1; tick();
    chk("p2_select", 32'(bus.select), 32'h020);
    chk("p2_player", 32'(bus.player), 1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) bus.key_up = 1;
      if (i == 3) bus.key_up = 0;
      tick();
      if (bus.select != 0) pulses++;
    end
    chk("hold_extra_pulses", 32'(pulses), 0);
    chk("hold_row", 32'(bus.row), 1);
    chk("p2_player_post", 32'(bus.player), 0);
    chk("p2_count", 32'(bus.move_count), 2);
    bus.key_place = 0; tick();
    bus.occupied = 9'h030;

    // move to (2,1) and place
    bus.key_left = 1; tick(); bus.key_left = 0; tick();
    bus.key_down = 1; tick(); bus.key_down = 0; tick();
    bus.key_place = 1; tick();
    chk("p3_select", 32'(bus.select), 32'h080);
    chk("p3_player", 32'(bus.player), 0);
    bus.key_place = 0; tick(); tick();
    bus.occupied = 9'h0B0;

    // up+down cancel, left applies
    bus.key_up = 1; bus.key_down = 1; bus.key_left = 1; tick();
    chk("ud_cancel_row", 32'(bus.row), 2);
    chk("left_col", 32'(bus.col), 0);
    bus.key_up = 0; bus.key_down = 0; bus.key_left = 0; tick();

    // place + right together: place at (2,0), cursor stays
    bus.key_place = 1; bus.key_right = 1; tick();
    chk("p4_select", 32'(bus.select), 32'h040);
    chk("p4_col", 32'(bus.col), 0);
    bus.key_place = 0; bus.key_right = 0; tick(); tick();
    chk("p4_count", 32'(bus.move_count), 4);
    chk("p4_player", 32'(bus.player), 0);

    // 6. reset asserted during COMMIT at (0,0)
    bus.key_up = 1; tick(); bus.key_up = 0; tick();
    bus.key_up = 1; tick(); bus.key_up = 0; tick();
    bus.key_place = 1; tick();
    chk("p5_select", 32'(bus.select), 32'h001);
    rst = 1; tick();
    chk("rc_select", 32'(bus.select), 0);
    chk("rc_player", 32'(bus.player), 0);
    chk("rc_count", 32'(bus.move_count), 0);
    rst = 0; bus.key_place = 0; bus.occupied = '0; tick();

    // nine accepted moves, then saturation
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      bus.key_place = 1; tick();
      if (bus.select == 9'h001) pulses++;
      bus.key_place = 0; tick(); tick();
    end
    chk("nine_pulses", 32'(pulses), 9);
    chk("nine_count", 32'(bus.move_count), 9);
    bus.key_place = 1; tick();
    chk("full_select", 32'(bus.select), 0);
    bus.key_place = 0; tick(); tick();
    chk("full_count", 32'(bus.move_count), 9);
    chk("full_player", 32'(bus.player), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
